// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM/WB capture inputs plus register-file write and status outputs.
// master = upstream pipeline / bench side, slave = wb_stage.
interface wb_stage_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DW     = 32
);
    logic              i_stall;
    logic              i_flush;
    logic              i_valid;
    logic [DW-1:0]     i_pc;
    logic [DW-1:0]     i_alu_data;
    logic [DW-1:0]     i_ld_data;
    logic [2:0]        i_ld_type;
    logic [1:0]        i_wb_sel;
    logic              i_rd_wren;
    logic [REG_AW-1:0] i_rd_addr;

    logic              o_rd_wren;
    logic [REG_AW-1:0] o_rd_addr;
    logic [DW-1:0]     o_rd_data;
    logic              o_valid;
    logic [31:0]       o_retire_cnt;
    logic              o_ld_misalign;

    modport master (
        output i_stall, i_flush, i_valid, i_pc, i_alu_data, i_ld_data,
               i_ld_type, i_wb_sel, i_rd_wren, i_rd_addr,
        input  o_rd_wren, o_rd_addr, o_rd_data, o_valid, o_retire_cnt, o_ld_misalign
    );

    modport slave (
        input  i_stall, i_flush, i_valid, i_pc, i_alu_data, i_ld_data,
               i_ld_type, i_wb_sel, i_rd_wren, i_rd_addr,
        output o_rd_wren, o_rd_addr, o_rd_data, o_valid, o_retire_cnt, o_ld_misalign
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback mux and retire counter.
// Define WB_LD_MISALIGN_CHK_EN to flag misaligned loads and suppress their write.
module wb_stage #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DW     = 32
) (
    input logic        i_clk,
    input logic        i_rst,
    wb_stage_if.slave  bus
);
    localparam logic [2:0] LdLb  = 3'b000;
    localparam logic [2:0] LdLh  = 3'b001;
    localparam logic [2:0] LdLbu = 3'b100;
    localparam logic [2:0] LdLhu = 3'b101;

    logic              valid_q;
    logic [DW-1:0]     pc_q;
    logic [DW-1:0]     alu_q;
    logic [DW-1:0]     ld_q;
    logic [2:0]        ld_type_q;
    logic [1:0]        wb_sel_q;
    logic              rd_wren_q;
    logic [REG_AW-1:0] rd_addr_q;
    logic [31:0]       retire_cnt_q;

    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DW-1:0]     ld_ext;
    logic              misalign;

    // Flush wins over stall; the bubble keeps the other fields, only valid drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            alu_q        <= '0;
            ld_q         <= '0;
            ld_type_q    <= '0;
            wb_sel_q     <= '0;
            rd_wren_q    <= 1'b0;
            rd_addr_q    <= '0;
            retire_cnt_q <= '0;
        end else if (bus.i_flush) begin
            valid_q <= 1'b0;
        end else if (!bus.i_stall) begin
            valid_q      <= bus.i_valid;
            pc_q         <= bus.i_pc;
            alu_q        <= bus.i_alu_data;
            ld_q         <= bus.i_ld_data;
            ld_type_q    <= bus.i_ld_type;
            wb_sel_q     <= bus.i_wb_sel;
            rd_wren_q    <= bus.i_rd_wren;
            rd_addr_q    <= bus.i_rd_addr;
            if (bus.i_valid) retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    always_comb begin
        byte_v = ld_q[7:0];
        case (alu_q[1:0])
            2'd1:    byte_v = ld_q[15:8];
            2'd2:    byte_v = ld_q[23:16];
            2'd3:    byte_v = ld_q[31:24];
            default: byte_v = ld_q[7:0];
        endcase
        half_v = alu_q[1] ? ld_q[31:16] : ld_q[15:0];

        ld_ext = ld_q;
        case (ld_type_q)
            LdLb:    ld_ext = {{(DW-8){byte_v[7]}}, byte_v};
            LdLh:    ld_ext = {{(DW-16){half_v[15]}}, half_v};
            LdLbu:   ld_ext = {{(DW-8){1'b0}}, byte_v};
            LdLhu:   ld_ext = {{(DW-16){1'b0}}, half_v};
            default: ld_ext = ld_q;
        endcase
    end

`ifdef WB_LD_MISALIGN_CHK_EN
    logic is_half;
    logic is_word;

    always_comb begin
        is_half  = (ld_type_q == LdLh) || (ld_type_q == LdLhu);
        // Unlisted type codes behave as LW, so they get the word alignment rule.
        is_word  = !(is_half || (ld_type_q == LdLb) || (ld_type_q == LdLbu));
        misalign = valid_q && (wb_sel_q == 2'b01) &&
                   ((is_half && alu_q[0]) || (is_word && (alu_q[1:0] != 2'b00)));
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        bus.o_rd_data = '0;
        case (wb_sel_q)
            2'b00:   bus.o_rd_data = alu_q;
            2'b01:   bus.o_rd_data = ld_ext;
            2'b10:   bus.o_rd_data = pc_q + DW'(4);
            default: bus.o_rd_data = '0;
        endcase
    end

    assign bus.o_rd_wren     = valid_q && rd_wren_q && (rd_addr_q != '0) && !misalign;
    assign bus.o_rd_addr     = rd_addr_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_retire_cnt  = retire_cnt_q;
    assign bus.o_ld_misalign = misalign;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
- REQ-001: Parameter REG_AW, default 5, register-file address width.
- REQ-002: Parameter DW, default 32, datapath width.
- REQ-003: i_clk  input  1  clock; all state updates on the rising edge.
- REQ-004: i_rst  input  1  reset, asynchronous, active-high.
- REQ-005: i_stall  input  1  hold the MEM/WB register contents.
- REQ-006: i_flush  input  1  replace the next captured entry with a bubble.
- REQ-007: i_valid  input  1  upstream instruction valid.
- REQ-008: i_pc  input  DW  instruction PC.
- REQ-009: i_alu_data  input  DW  ALU result / load address.
- REQ-010: i_ld_data  input  DW  raw load word from the memory stage.
- REQ-011: i_ld_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW.
- REQ-012: i_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 zero.
- REQ-013: i_rd_wren  input  1  destination write request.
- REQ-014: i_rd_addr  input  REG_AW  destination register.
- REQ-015: o_rd_wren  output  1  register-file write enable.
- REQ-016: o_rd_addr  output  REG_AW  register-file write address.
- REQ-017: o_rd_data  output  DW  register-file write data.
- REQ-018: o_valid  output  1  the MEM/WB slot holds a valid instruction.
- REQ-019: o_retire_cnt  output  32  retired-instruction counter.
- REQ-020: o_ld_misalign  output  1  misaligned-load flag (see Configuration).

Function
- REQ-021: The MEM/WB register (valid, pc, alu_data, ld_data, ld_type, wb_sel, rd_wren, rd_addr) SHALL capture all inputs on a rising edge when i_stall=0 and i_flush=0.
- REQ-022: i_flush=1 SHALL clear the registered valid on the next edge regardless of i_stall; flush has priority over stall.
- REQ-023: i_stall=1 with i_flush=0 SHALL hold every registered field unchanged.
- REQ-024: Latency SHALL be exactly one cycle from capture to o_rd_* and o_valid; o_rd_* are combinational from the registered fields.
- REQ-025: Load lane selection SHALL use registered alu_data[1:0].
  - Byte: lane = addr[1:0].
  - Half: lane = addr[1]; bits [15:0] for 0, [31:16] for 1.
- REQ-026: Extension: LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
- REQ-027: PC+4 SHALL be computed modulo 2^32; 0xFFFFFFFC SHALL yield 0x00000000.
- REQ-028: o_rd_wren SHALL equal valid AND rd_wren AND (rd_addr != 0).
- REQ-029: o_rd_data SHALL be driven per wb_sel even when o_rd_wren=0.
- REQ-030: o_retire_cnt SHALL increment by 1 on each edge where a valid entry is captured (i_valid=1, i_stall=0, i_flush=0).
- REQ-031: o_retire_cnt SHALL wrap from 0xFFFFFFFF to 0.
- REQ-032: A stalled cycle SHALL NOT increment o_retire_cnt, and SHALL NOT cause a second write of the held entry to be counted.

Reset
- REQ-033: i_rst=1 SHALL immediately clear every registered field and o_retire_cnt to 0.
  - Consequence: o_valid=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_ld_misalign=0.
- REQ-034: Reset asserted mid-stall or mid-flush SHALL override both.
- REQ-035: The first capture SHALL occur on the first rising edge after deassertion.

Configuration
- REQ-036: Macro WB_LD_MISALIGN_CHK_EN SHALL control misaligned-load checking.
- REQ-037: With WB_LD_MISALIGN_CHK_EN defined, a valid entry with wb_sel=01 SHALL be flagged misaligned when either holds:
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]!=0.
- REQ-038: A flagged misaligned entry SHALL drive o_ld_misalign=1 and o_rd_wren=0 for that cycle, and SHALL still be counted retired.
- REQ-039: Without WB_LD_MISALIGN_CHK_EN, o_ld_misalign SHALL be tied 0, and no write SHALL be suppressed.
  - Halfwords use addr[1] only.
  - LW ignores addr[1:0].

Verification
- REQ-040: LB, ld_data=0x80FF7F01, addr=...2, rd=5, wb_sel=01 -> next cycle o_rd_data=0xFFFFFFFF, o_rd_wren=1, o_rd_addr=5.
- REQ-041: LHU, ld_data=0x8001ABCD, addr=...2 -> o_rd_data=0x00008001; the same case with LH -> 0xFFFF8001.
- REQ-042: wb_sel=10, pc=0x00000100, rd=0 -> o_rd_data=0x00000104, o_rd_wren=0; o_retire_cnt increments by 1.
- REQ-043: Capture entry A, then assert i_stall 3 cycles with new inputs, then assert i_flush with i_stall=1:
  - during the stall, o_rd_* hold A's values;
  - o_retire_cnt increments once;
  - after the flush, o_valid=0.
- REQ-044: Preload o_retire_cnt to 0xFFFFFFFF via 2^32-1 valid captures (or a forced value in simulation), then capture one valid entry -> o_retire_cnt=0. Then assert i_rst asynchronously between edges -> all outputs 0 immediately.
- REQ-045: With WB_LD_MISALIGN_CHK_EN defined, LW at addr 0x...1 -> o_ld_misalign=1, o_rd_wren=0. With the macro undefined, the same stimulus -> o_ld_misalign=0, o_rd_wren=1, o_rd_data=ld_data.
